// File: rtl/demux5_buf.sv
`timescale 1ns/1ps
// demux5_buf: five-way buffered dispatcher.
// One valid/ready source stream is routed by in_sel to one of five
// destination streams (a..e), each behind its own DEPTH-entry FIFO.
// Select codes 5..7 are routed to destination a and raise the sticky bad_sel.
//
// Ports:
//   clk, resetn          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready    source handshake; in_sel picks destination, in_data is the word
//   out_valid[4:0]       per-destination valid (bit0=a .. bit4=e)
//   out_ready[4:0]       per-destination ready, same bit order
//   out_data_a..e        head word of each FIFO, zero when that FIFO is empty
//   bad_sel              sticky: a word with in_sel >= 5 was accepted
module demux5_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic [4:0]       out_valid,
    input  logic [4:0]       out_ready,
    output logic [WIDTH-1:0] out_data_a,
    output logic [WIDTH-1:0] out_data_b,
    output logic [WIDTH-1:0] out_data_c,
    output logic [WIDTH-1:0] out_data_d,
    output logic [WIDTH-1:0] out_data_e,
    output logic             bad_sel
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [2:0]       tgt;
    logic             push;
    logic [4:0]       pop;
    logic [4:0]       push_i;

    logic [PW-1:0]    wr_ptr_q [5];
    logic [PW-1:0]    wr_ptr_d [5];
    logic [PW-1:0]    rd_ptr_q [5];
    logic [PW-1:0]    rd_ptr_d [5];
    logic [CW-1:0]    cnt_q    [5];
    logic [CW-1:0]    cnt_d    [5];
    logic             bad_sel_q;
    logic             bad_sel_d;

    logic [WIDTH-1:0] mem_q    [5][DEPTH];
    logic [WIDTH-1:0] head     [5];

    // Ready depends only on the selected FIFO's registered count, so a full
    // FIFO blocks the source even if it is popping in the same cycle.
    always_comb begin
        tgt       = (in_sel <= 3'd4) ? in_sel : 3'd0;
        in_ready  = resetn && (cnt_q[tgt] < CW'(DEPTH));
        push      = in_valid && in_ready;
        bad_sel_d = bad_sel_q | (push && (in_sel > 3'd4));
        for (int unsigned i = 0; i < 5; i++) begin
            push_i[i]   = push && (tgt == 3'(i));
            pop[i]      = (cnt_q[i] != '0) && out_ready[i];
            wr_ptr_d[i] = wr_ptr_q[i] + PW'(push_i[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
            case ({push_i[i], pop[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < 5; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            bad_sel_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 5; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            bad_sel_q <= bad_sel_d;
        end
    end

    // Storage is not reset: contents are only observable through a non-zero
    // count, and reset clears every count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tgt][wr_ptr_q[tgt]] <= in_data;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 5; i++) begin
            out_valid[i] = (cnt_q[i] != '0);
            head[i]      = (cnt_q[i] != '0) ? mem_q[i][rd_ptr_q[i]] : '0;
        end
    end

    assign out_data_a = head[0];
    assign out_data_b = head[1];
    assign out_data_c = head[2];
    assign out_data_d = head[3];
    assign out_data_e = head[4];
    assign bad_sel    = bad_sel_q;

endmodule

// File: tb/tb_demux5_buf.sv
`timescale 1ns/1ps
// Bench for demux5_buf: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a queue-based model.
module tb_demux5_buf;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    typedef logic [WIDTH-1:0] word_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_sel = '0;
    word_t       in_data = '0;
    logic [4:0]  out_valid;
    logic [4:0]  out_ready = '0;
    word_t       out_data_a, out_data_b, out_data_c, out_data_d, out_data_e;
    logic        bad_sel;
    word_t       od [5];

    demux5_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data_a (out_data_a),
        .out_data_b (out_data_b),
        .out_data_c (out_data_c),
        .out_data_d (out_data_d),
        .out_data_e (out_data_e),
        .bad_sel    (bad_sel)
    );

    assign od[0] = out_data_a;
    assign od[1] = out_data_b;
    assign od[2] = out_data_c;
    assign od[3] = out_data_d;
    assign od[4] = out_data_e;

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: one queue per destination plus the sticky flag.
    word_t mq [5][$];
    bit    mbad = 1'b0;

    always @(negedge resetn) begin
        for (int i = 0; i < 5; i++) mq[i].delete();
        mbad = 1'b0;
    end

    always @(posedge clk) begin
        int  t;
        bit  acc;
        if (resetn) begin
            t   = (int'(in_sel) <= 4) ? int'(in_sel) : 0;
            acc = in_valid && (mq[t].size() < DEPTH);
            for (int i = 0; i < 5; i++)
                if (mq[i].size() != 0 && out_ready[i]) void'(mq[i].pop_front());
            if (acc) begin
                mq[t].push_back(in_data);
                if (int'(in_sel) > 4) mbad = 1'b1;
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        int    t;
        word_t hd;
        t = (int'(in_sel) <= 4) ? int'(in_sel) : 0;
        check("in_ready", 32'(in_ready), 32'(resetn && (mq[t].size() < DEPTH)));
        for (int i = 0; i < 5; i++) begin
            hd = (mq[i].size() != 0) ? mq[i][0] : '0;
            check($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(mq[i].size() != 0));
            check($sformatf("out_data[%0d]", i), od[i], hd);
        end
        check("bad_sel", 32'(bad_sel), 32'(mbad));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with a word presented
        resetn = 1'b0; in_valid = 1'b1; in_sel = 3'd2; in_data = 32'hDEAD_BEEF;
        repeat (3) step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data_c", out_data_c, 32'd0);
        check("rst_bad_sel", 32'(bad_sel), 32'd0);
        in_valid = 1'b0; resetn = 1'b1;
        #1 check("rel_in_ready", 32'(in_ready), 32'd1);

        // Single routing to d
        in_valid = 1'b1; in_sel = 3'd3; in_data = 32'h1111_1111;
        step();
        in_valid = 1'b0;
        check("single_valid", 32'(out_valid), 32'h08);
        check("single_data_d", out_data_d, 32'h1111_1111);
        out_ready = 5'b01000;
        step();
        out_ready = '0;
        check("single_popped", 32'(out_valid), 32'h00);

        // Full FIFO b blocks only words for b
        in_valid = 1'b1; in_sel = 3'd1; in_data = 32'hA0;
        step();
        in_data = 32'hA1;
        step();
        in_data = 32'hA2;
        #1 check("full_b_ready", 32'(in_ready), 32'd0);
        in_sel = 3'd2; in_data = 32'hC0;
        #1 check("c_ready_while_b_full", 32'(in_ready), 32'd1);
        step();
        check("c_head", out_data_c, 32'hC0);
        in_sel = 3'd1; in_data = 32'hA2;
        #1 check("b_still_full", 32'(in_ready), 32'd0);
        check("b_head0", out_data_b, 32'hA0);
        out_ready = 5'b00010;
        step();
        check("b_head1", out_data_b, 32'hA1);
        check("b_ready_after_pop", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("b_head2", out_data_b, 32'hA2);
        step();
        check("b_drained", 32'(out_valid), 32'h04);
        out_ready = '1;
        step();
        out_ready = '0;
        check("all_drained", 32'(out_valid), 32'h00);

        // Simultaneous push/pop on e
        in_valid = 1'b1; in_sel = 3'd4; in_data = 32'hE0;
        step();
        in_data = 32'hE1; out_ready = 5'b10000;
        step();
        in_valid = 1'b0; out_ready = '0;
        check("e_pushpop_valid", 32'(out_valid), 32'h10);
        check("e_pushpop_head", out_data_e, 32'hE1);
        out_ready = 5'b10000;
        step();
        out_ready = '0;
        check("e_empty", 32'(out_valid), 32'h00);

        // Bad select goes to a and sticks
        in_valid = 1'b1; in_sel = 3'd6; in_data = 32'h55;
        step();
        in_valid = 1'b0;
        check("bad_valid", 32'(out_valid), 32'h01);
        check("bad_data_a", out_data_a, 32'h55);
        check("bad_flag", 32'(bad_sel), 32'd1);
        out_ready = '1;
        repeat (3) step();
        out_ready = '0;
        check("bad_sticky", 32'(bad_sel), 32'd1);

        // Mid-operation reset pulse between edges
        in_valid = 1'b1; in_sel = 3'd0; in_data = 32'h0A0;
        step();
        in_data = 32'h0A1;
        step();
        in_sel = 3'd2; in_data = 32'h0C1;
        step();
        in_valid = 1'b0;
        #1 check("pre_rst_valid", 32'(out_valid), 32'h05);
        #1 resetn = 1'b0;
        #0.5;
        check("mid_rst_valid", 32'(out_valid), 32'h00);
        check("mid_rst_data_a", out_data_a, 32'h0);
        check("mid_rst_bad", 32'(bad_sel), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        #0.5 resetn = 1'b1;
        step();
        check("post_rst_valid", 32'(out_valid), 32'h00);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_sel   = 3'($urandom_range(0, 7));
            in_data  = $urandom;
            for (int i = 0; i < 5; i++) out_ready[i] = ($urandom_range(0, 2) == 0);
            resetn   = ($urandom_range(0, 299) != 0);
            step();
        end
        in_valid = 1'b0; resetn = 1'b1; out_ready = '1;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
